// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: operating modes and
// controller states.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/shift_reg_univ_ctrl.sv
// Shift-count controller: tracks the shifts of a loaded word and pulses done
// once SHIFT_LEN of them have been counted.
module shift_ctrl
  import shift_reg_pkg::*;
#(
  parameter int SHIFT_LEN = 8,
  parameter int CNT_W     = $clog2(SHIFT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_cnt <= cnt_nxt;
      done      <= done_nxt;
    end
  end

  // Strobes arrive already qualified by en; done is a pulse, so it defaults low.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = shift_cnt;
    done_nxt  = 1'b0;
    if (load) begin
      state_nxt = ST_ACTIVE;
      cnt_nxt   = '0;
    end else if (shift && state == ST_ACTIVE) begin
      cnt_nxt = shift_cnt + CNT_W'(1);
      if (cnt_nxt == CNT_W'(SHIFT_LEN)) begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
    end
  end

  assign busy = (state == ST_ACTIVE);

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register datapath (hold/load/shift/rotate) with a shift-out
// counter. Rotate modes exist only when SHIFT_REG_ROTATE_EN is defined.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int SHIFT_LEN = WIDTH,
  localparam int CNT_W     = $clog2(SHIFT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt
);

  logic load, shift;

  assign load = en && (mode == MODE_LOAD);

  always_comb begin
    shift = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHL, MODE_SHR: shift = 1'b1;
`ifdef SHIFT_REG_ROTATE_EN
        MODE_ROL, MODE_ROR: shift = 1'b1;
`endif
        default: shift = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= '0;
      ser_out <= 1'b0;
    end else if (en) begin
      case (mode)
        MODE_LOAD: q <= data;
        MODE_SHL: begin
          q       <= {q[WIDTH-2:0], ser_in};
          ser_out <= q[WIDTH-1];
        end
        MODE_SHR: begin
          q       <= {ser_in, q[WIDTH-1:1]};
          ser_out <= q[0];
        end
`ifdef SHIFT_REG_ROTATE_EN
        MODE_ROL: begin
          q       <= {q[WIDTH-2:0], q[WIDTH-1]};
          ser_out <= q[WIDTH-1];
        end
        MODE_ROR: begin
          q       <= {q[0], q[WIDTH-1:1]};
          ser_out <= q[0];
        end
`endif
        default: ;
      endcase
    end
  end

  shift_ctrl #(
    .SHIFT_LEN (SHIFT_LEN),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .busy      (busy),
    .done      (done),
    .shift_cnt (shift_cnt)
  );

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=8, SHIFT_LEN=8): a behavioural
// model pushes expected outputs per driven cycle; they are popped after the edge.
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [WIDTH-1:0] data = '0;
  logic             ser_in = 1'b0;
  logic [WIDTH-1:0] q;
  logic             ser_out, busy, done;
  logic [3:0]       shift_cnt;

  shift_reg_univ #(.WIDTH(WIDTH), .SHIFT_LEN(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data(data),
    .ser_in(ser_in), .q(q), .ser_out(ser_out), .busy(busy), .done(done),
    .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;

  logic [7:0] m_q = '0;
  logic       m_so = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [3:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic si);
    bit counted = 1'b0;
    if (r) begin
      m_q = '0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = '0;
      return;
    end
    m_done = 1'b0;
    if (!e) return;
    case (m)
      3'd1: begin m_q = d; m_cnt = '0; m_busy = 1'b1; end
      3'd2: begin m_so = m_q[7]; m_q = (m_q << 1) | {7'b0, si}; counted = 1; end
      3'd3: begin m_so = m_q[0]; m_q = (m_q >> 1) | {si, 7'b0}; counted = 1; end
      3'd4: if (ROT) begin m_so = m_q[7]; m_q = (m_q << 1) | {7'b0, m_q[7]}; counted = 1; end
      3'd5: if (ROT) begin m_so = m_q[0]; m_q = (m_q >> 1) | {m_q[0], 7'b0}; counted = 1; end
      default: ;
    endcase
    if (counted && m_busy) begin
      m_cnt++;
      if (m_cnt == 4'd8) begin m_done = 1'b1; m_busy = 1'b0; end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] d, input logic si);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; mode = m; data = d; ser_in = si;
    model(r, e, m, d, si);
    x.q = m_q; x.so = m_so; x.busy = m_busy; x.done = m_done; x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".q"},    32'(q),         32'(x.q));
    chk({tag, ".so"},   32'(ser_out),   32'(x.so));
    chk({tag, ".busy"}, 32'(busy),      32'(x.busy));
    chk({tag, ".done"}, 32'(done),      32'(x.done));
    chk({tag, ".cnt"},  32'(shift_cnt), 32'(x.cnt));
  endtask

  initial begin
    // Reset dominates a pending load.
    step("rst", 1, 1, 3'd1, 8'hFF, 0);
    step("rst", 1, 1, 3'd1, 8'hFF, 0);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(shift_cnt), 0);

    step("shl_ld", 0, 1, 3'd1, 8'hA5, 0);
    step("shl", 0, 1, 3'd2, 8'h00, 1);
    chk("shl_q", 32'(q), 32'h4B);
    chk("shl_so", 32'(ser_out), 1);
    chk("shl_cnt", 32'(shift_cnt), 1);
    chk("shl_busy", 32'(busy), 1);

    step("shr_ld", 0, 1, 3'd1, 8'hA5, 0);
    step("shr", 0, 1, 3'd3, 8'h00, 0);
    chk("shr_q", 32'(q), 32'h52);
    chk("shr_so", 32'(ser_out), 1);
    for (int i = 0; i < 3; i++) step("en_gap", 0, 0, 3'd2, 8'h00, 1);
    chk("gap_q", 32'(q), 32'h52);
    chk("gap_cnt", 32'(shift_cnt), 1);

    step("rol_ld", 0, 1, 3'd1, 8'h81, 0);
    step("rol", 0, 1, 3'd4, 8'h00, 0);
    chk("rol_q", 32'(q), ROT ? 32'h03 : 32'h81);
    chk("rol_cnt", 32'(shift_cnt), ROT ? 1 : 0);

    step("cnt_ld", 0, 1, 3'd1, 8'h3C, 0);
    for (int i = 0; i < 8; i++) step("cnt_shl", 0, 1, 3'd2, 8'h00, 0);
    chk("co_done", 32'(done), 1);
    chk("co_busy", 32'(busy), 0);
    chk("co_cnt", 32'(shift_cnt), 8);
    chk("co_q", 32'(q), 32'h00);
    step("co_clr", 0, 0, 3'd2, 8'h00, 0);
    chk("co_done_clr", 32'(done), 0);
    step("co_idle", 0, 1, 3'd2, 8'h00, 1);
    chk("co_cnt_hold", 32'(shift_cnt), 8);

    step("rs_ld", 0, 1, 3'd1, 8'h3C, 0);
    for (int i = 0; i < 5; i++) step("rs_shl", 0, 1, 3'd2, 8'h00, 1);
    step("rs_reld", 0, 1, 3'd1, 8'h3C, 0);
    chk("rs_cnt", 32'(shift_cnt), 0);
    chk("rs_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) step("rs_shl2", 0, 1, 3'd2, 8'h00, 1);
    step("rs_rst", 1, 1, 3'd2, 8'h00, 1);
    chk("rs_rst_q", 32'(q), 0);
    chk("rs_rst_busy", 32'(busy), 0);
    chk("rs_rst_cnt", 32'(shift_cnt), 0);
    for (int i = 0; i < 8; i++) step("rs_after", 0, 1, 3'd2, 8'h00, 1);
    chk("rs_no_done", 32'(done), 0);

    // Random mix, biased towards loads and shifts so the count-out path is hit.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] m;
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
      step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), m,
           8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the successor to our single-bit D flip-flop, generalised to WIDTH bits with hold, parallel load, and serial shift left/right modes. A built-in shift counter and a two-state controller flag when a loaded word has been shifted out. It sits between parallel datapaths and serial links (SPI/UART-style framers) in the project designs.

## Interface
- WIDTH, 8: register width in bits; must be at least 2.
- SHIFT_LEN, WIDTH: number of counted shifts after a load before `done`; must be in 1..WIDTH.
- CNT_W, $clog2(SHIFT_LEN+1): local parameter, width of `shift_cnt`.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  clock enable; when low, q, ser_out, the count and the state hold.
- mode  in  3  operating mode:
  - 0 hold
  - 1 load
  - 2 shift left
  - 3 shift right
  - 4 rotate left
  - 5 rotate right
  - 6 and 7 hold
- data  in  WIDTH  parallel load value.
- ser_in  in  1  serial input bit for shifts.
- q  out  WIDTH  register contents.
- ser_out  out  1  bit shifted or rotated out by the most recent shift or rotate; holds otherwise.
- busy  out  1  high while a loaded word is being counted out.
- done  out  1  one-cycle pulse when the count reaches SHIFT_LEN.
- shift_cnt  out  CNT_W  counted shifts since the last load.

## Operation
- All outputs are registered. Reset values: q=0, ser_out=0, busy=0, done=0, shift_cnt=0, state IDLE.
- Reset has priority over en and mode.
- Mode behaviour, applied on a clock edge with en=1:
  - Load: q<=data, shift_cnt<=0, state ACTIVE (busy=1). A load while ACTIVE restarts the count. ser_out holds.
  - Shift left: q<={q[WIDTH-2:0],ser_in}, ser_out<=q[WIDTH-1].
  - Shift right: q<={ser_in,q[WIDTH-1:1]}, ser_out<=q[0].
  - Rotate left/right: same as the shifts, except the bit shifted out re-enters at the opposite end and ser_in is ignored. ser_out takes the bit that wrapped.
  - Hold (modes 0, 6, 7): nothing changes.
- State machine:
  - IDLE: shifts and rotates change q and ser_out but do not count.
  - ACTIVE: each shift or rotate increments shift_cnt. On the edge where the count becomes SHIFT_LEN, the block sets done=1 and busy=0 and returns to IDLE. shift_cnt then holds at SHIFT_LEN until the next load.
- done is a single-cycle pulse. It clears on the following edge regardless of en.
- With en=0, done still clears. Nothing else changes.

## Timing
- Load to q valid: 1 cycle.
- Each shift takes effect on the edge where it is sampled.
- done is asserted in the cycle immediately after the SHIFT_LEN-th counted shift edge. busy falls on that same edge.
- When a load coincides with done being high, done still clears, and busy and the count restart from the load.
- No combinational path from any input to any output.

## Configuration
- SHIFT_REG_ROTATE_EN defined: modes 4 and 5 rotate as described and count as shifts.
- SHIFT_REG_ROTATE_EN undefined: modes 4 and 5 behave as hold, and no rotate logic is synthesised.

## Structure
- Package shift_reg_pkg holds:
  - the mode encodings as localparams: MODE_HOLD=0, MODE_LOAD=1, MODE_SHL=2, MODE_SHR=3, MODE_ROL=4, MODE_ROR=5;
  - the state encodings: ST_IDLE=0, ST_ACTIVE=1.
- Sub-module shift_ctrl contains the IDLE/ACTIVE state machine, the shift counter, busy and done. Its inputs are the load and shift strobes. The top level contains the datapath only.

## Test plan
All scenarios use WIDTH=8 and SHIFT_LEN=8.
- Reset: assert reset for 2 cycles with mode=1 and data=0xFF -> q=0x00, busy=0, done=0, shift_cnt=0.
- Left shift: load 0xA5, then shift left with ser_in=1 -> q=0x4B, ser_out=1, shift_cnt=1, busy=1.
- Right shift with enable gap: load 0xA5, then shift right with ser_in=0 -> q=0x52, ser_out=1. Then hold en=0 for 3 cycles with mode=2 -> q stays 0x52 and shift_cnt stays 1.
- Rotate with SHIFT_REG_ROTATE_EN defined: load 0x81, then rotate left -> q=0x03, ser_out=1.
- Rotate with SHIFT_REG_ROTATE_EN undefined: same stimulus -> q=0x81, shift_cnt=0.
- Count-out: load 0x3C, then 8 shift-left cycles -> done high for exactly one cycle after the 8th edge, busy=0, shift_cnt=8, q=0x00 when ser_in=0.
- Restart and reset: load 0x3C at shift 5 -> shift_cnt=0 and busy stays 1. Assert reset at shift 3 -> all outputs return to their reset values the next cycle, and no done pulse occurs.
